// File: rtl/btn_pulse_gen.sv
// Debounces a bouncing button level and emits one x pulse per accepted rising edge.
// Latency: DB_CYCLES+3 edges from din change to level/x (3 edges without DEBOUNCE_EN).
// Backpressure: none; free-running, consumer must take x the cycle it is high.
// Optional feature macro: DEBOUNCE_EN compiles in the stability counter.
module btn_pulse_gen #(
  parameter int unsigned DB_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic x,
  output logic level
);

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } state_t;

  state_t state, state_nx;
  logic   s1, s2;
  logic   x_nx;
  logic   level_nx;

  // Refuse to elaborate with a stability window the 8-bit counter cannot express.
  if (DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_db_range_err
    $error("btn_pulse_gen: DB_CYCLES must be in 1..255");
  end

`ifdef DEBOUNCE_EN
  localparam logic [7:0] CNT_LAST = 8'(DB_CYCLES - 1);
  logic [7:0] cnt, cnt_nx;
`endif

  // Two-flop synchronizer; only s2 is allowed to reach the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // State register plus registered outputs, all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOW;
      x     <= 1'b0;
      level <= 1'b0;
    end else begin
      state <= state_nx;
      x     <= x_nx;
      level <= level_nx;
    end
  end

`ifdef DEBOUNCE_EN
  // Stability counter; it is only ever loaded with 0 or incremented below CNT_LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt_nx;
    end
  end
`endif

  // Next-state logic: a level change is accepted only after enough stable samples.
  always_comb begin
    state_nx = state;
    x_nx     = 1'b0;
`ifdef DEBOUNCE_EN
    cnt_nx   = cnt;
`endif
    case (state)
      LOW: begin
        if (s2) begin
`ifdef DEBOUNCE_EN
          state_nx = RISE_CHK;
          cnt_nx   = 8'd0;
`else
          state_nx = HIGH;
          x_nx     = 1'b1;
`endif
        end
      end
      RISE_CHK: begin
`ifdef DEBOUNCE_EN
        if (!s2) begin
          state_nx = LOW;
        end else if (cnt == CNT_LAST) begin
          state_nx = HIGH;
          x_nx     = 1'b1;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
`else
        state_nx = LOW;
`endif
      end
      HIGH: begin
        if (!s2) begin
`ifdef DEBOUNCE_EN
          state_nx = FALL_CHK;
          cnt_nx   = 8'd0;
`else
          state_nx = LOW;
`endif
        end
      end
      FALL_CHK: begin
`ifdef DEBOUNCE_EN
        if (s2) begin
          state_nx = HIGH;
        end else if (cnt == CNT_LAST) begin
          state_nx = LOW;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
`else
        state_nx = HIGH;
`endif
      end
      default: state_nx = LOW;
    endcase
    level_nx = (state_nx == HIGH) || (state_nx == FALL_CHK);
  end

endmodule

// File: doc/btn_pulse_gen.md
BTN_PULSE_GEN -- requirements
Module: btn_pulse_gen

Interface
REQ-001 The block SHALL have one parameter: DB_CYCLES, default 8, the number of consecutive stable synchronized samples required to accept a level change (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port din, input, 1 bit: raw asynchronous, bouncing button/level input.
REQ-005 The block SHALL have port x, output, 1 bit: registered single-cycle pulse per accepted rising edge; drives the x input of the downstream mod-4 pulse counter FSM.
REQ-006 The block SHALL have port level, output, 1 bit: registered debounced level of din.

Function
REQ-007 din SHALL pass through a two-flop synchronizer (s1, s2); only s2 feeds the FSM.
REQ-008 The FSM SHALL have four states: LOW, RISE_CHK, HIGH, FALL_CHK, plus an 8-bit stability counter cnt.
REQ-009 In LOW, s2=1 SHALL move to RISE_CHK with cnt<=0; otherwise hold.
REQ-010 In RISE_CHK, s2=0 SHALL return to LOW (glitch rejected, no pulse); s2=1 with cnt==DB_CYCLES-1 SHALL move to HIGH; otherwise cnt<=cnt+1.
REQ-011 In HIGH, s2=0 SHALL move to FALL_CHK with cnt<=0; otherwise hold.
REQ-012 In FALL_CHK, s2=1 SHALL return to HIGH with no new pulse; s2=0 with cnt==DB_CYCLES-1 SHALL move to LOW; otherwise cnt<=cnt+1.
REQ-013 x SHALL be 1 for exactly the one cycle following the edge at which the state enters HIGH from RISE_CHK (or from LOW, per REQ-020), and 0 otherwise; FALL_CHK->HIGH SHALL NOT pulse.
REQ-014 level SHALL be 1 exactly when the registered state is HIGH or FALL_CHK.
REQ-015 Latency: with din rising before edge 1 and held stable, x SHALL be high after edge DB_CYCLES+3 (edge 11 for default); level SHALL rise on the same edge.
REQ-016 Falling latency: level SHALL fall after edge DB_CYCLES+3 counted from the first edge sampling din=0.
REQ-017 Minimum spacing: consecutive x pulses SHALL be separated by at least 2*DB_CYCLES+2 cycles; x SHALL never be high two consecutive cycles.
REQ-018 cnt SHALL never exceed DB_CYCLES-1 and SHALL never wrap.

Reset
REQ-019 When rst=1 at a clock edge, s1, s2, cnt, x and level SHALL become 0 and state LOW, overriding all other activity, including mid-RISE_CHK/FALL_CHK; if din is high after reset release, a fresh pulse SHALL be produced after the full REQ-015 latency.

Configuration
REQ-020 Macro DEBOUNCE_EN SHALL compile in the stability counter. Without it: no cnt register, RISE_CHK/FALL_CHK unreachable, LOW->HIGH on s2=1 (with x pulse) and HIGH->LOW on s2=0, giving a latency of 3 edges; DB_CYCLES is ignored.

Verification
REQ-021 Reset then din held 0 for 50 cycles -> x=0, level=0 throughout.
REQ-022 DB_CYCLES=8, din 0->1 held 30 cycles -> x high for exactly one cycle after edge 11, level=1 from edge 11.
REQ-023 din high for 5 cycles then low (shorter than debounce) -> no x pulse, level stays 0.
REQ-024 Stable high, then din low for 3 cycles, then high -> level remains 1, no second x pulse.
REQ-025 rst asserted for 1 cycle mid-RISE_CHK with din held 1 -> x=0 and level=0 after the reset edge; single x pulse 11 edges after release.
REQ-026 Four clean presses fed into the downstream mod-4 counter FSM -> exactly four x pulses and the counter's y asserted after the third.
